// File: rtl/bus_arbiter2.sv
// Two-requester round-robin bus arbiter with bounded hold time.
// Drives the 2:1 mux select and registers the owner's data onto the shared bus.
module bus_arbiter2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_valid
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e                  state_q, state_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic                    last_q, last_d;
  logic                    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   bus_q, bus_d;
  logic                    valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    sel_d   = sel_q;
    bus_d   = bus_q;
    valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          state_d = req1 ? StOwn1 : StIdle;
        end else if (req1 && hold_q == HoldMax) begin
          state_d = StOwn1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
        if (req0) begin
          bus_d   = din0;
          valid_d = 1'b1;
        end
      end
      StOwn1: begin
        if (!req1) begin
          state_d = req0 ? StOwn0 : StIdle;
        end else if (req0 && hold_q == HoldMax) begin
          state_d = StOwn0;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
        if (req1) begin
          bus_d   = din1;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Entering an ownership state restarts the hold window and records the owner.
    if (state_d != state_q && state_d == StOwn0) begin
      hold_d = '0;
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d != state_q && state_d == StOwn1) begin
      hold_d = '0;
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
    end
  end

  assign gnt0      = (state_q == StOwn0);
  assign gnt1      = (state_q == StOwn1);
  assign sel       = sel_q;
  assign bus_out   = bus_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 (DATA_WIDTH=8, MAX_HOLD=4).
module tb_bus_arbiter2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, sel, bus_valid;
  logic [7:0] bus_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter2 #(
    .DATA_WIDTH(8),
    .MAX_HOLD  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .din0     (din0),
    .din1     (din1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .bus_out  (bus_out),
    .bus_valid(bus_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic g0, input logic g1, input logic s,
                         input logic [7:0] b, input logic v);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".bus_out"}, 32'(bus_out), 32'(b));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
  endtask

  initial begin
    // Reset held for two edges with both requesting.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 8'hA0; din1 = 8'hB0;
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // First edge after release: requester 0 wins (last_owner=1).
    rst_n = 1'b1;
    step();
    chk_all("first_grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Continuous contention: 4 din0 words then 4 din1 words, no bubbles.
    for (int c = 1; c <= 8; c++) begin
      din0 = 8'hA0 + 8'(c);
      din1 = 8'hB0 + 8'(c);
      step();
      chk_all($sformatf("contend%0d", c), !(c >= 4 && c <= 7), (c >= 4 && c <= 7),
              (c >= 4 && c <= 7), (c <= 4) ? 8'hA0 + 8'(c) : 8'hB0 + 8'(c), 1'b1);
    end

    // Owner 0 (granted at last edge) keeps one more cycle, then releases.
    din0 = 8'hA9;
    step();
    chk_all("own0_second", 1'b1, 1'b0, 1'b0, 8'hA9, 1'b1);
    req0 = 1'b0; din0 = 8'hCC; din1 = 8'hD0;
    step();
    chk_all("early_release", 1'b0, 1'b1, 1'b1, 8'hA9, 1'b0);
    din1 = 8'hD1;
    step();
    chk_all("after_release", 1'b0, 1'b1, 1'b1, 8'hD1, 1'b1);

    // Reset in the middle of OWN1.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step();
    chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset_grant", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Single requester 1 for ten cycles: no handoff, data one edge late.
    req0 = 1'b0; req1 = 1'b1; din1 = 8'h0F;
    step();
    chk_all("single_enter", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      din1 = 8'h10 + 8'(c);
      step();
      chk_all($sformatf("single%0d", c), 1'b0, 1'b1, 1'b1, 8'h10 + 8'(c), 1'b1);
    end

    // Hold count saturated at 3: a new competitor takes over on the next edge.
    req0 = 1'b1; din0 = 8'h55; din1 = 8'h99;
    step();
    chk_all("sat_handoff", 1'b1, 1'b0, 1'b0, 8'h99, 1'b1);

    // Simultaneous release by owner 0 and request by 1: direct move, no IDLE.
    req0 = 1'b0; din1 = 8'h77;
    step();
    chk_all("direct_move", 1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
    din1 = 8'h78;
    step();
    chk_all("own1_data", 1'b0, 1'b1, 1'b1, 8'h78, 1'b1);

    // Idle gap: bus_out and sel keep their last values.
    req1 = 1'b0; din0 = 8'h11; din1 = 8'h22;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_all($sformatf("idle%0d", c), 1'b0, 1'b0, 1'b1, 8'h78, 1'b0);
    end

    // Contention from IDLE after owner 1: requester 0 wins.
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk_all("rr_from_idle", 1'b1, 1'b0, 1'b0, 8'h78, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
